// File: rtl/instr_encoder.sv
// Program-load encoder: turns a stream of mnemonic descriptors into 32-bit
// MIPS-style words and writes them to consecutive instruction-memory addresses.
module instr_encoder #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [4:0]            kind_i,
    input  logic [4:0]            rs_i,
    input  logic [4:0]            rt_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            shamt_i,
    input  logic [15:0]           imm_i,
    input  logic [25:0]           target_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [31:0]           wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    function automatic logic [ADDR_WIDTH:0] sat_len(input logic [ADDR_WIDTH:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    function automatic logic is_legal(input logic [4:0] kind);
        return kind <= 5'd18;
    endfunction

    function automatic logic [31:0] encode(
        input logic [4:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [5:0] funct;
        logic [5:0] op;
        logic [31:0] word;
        funct = 6'b000000;
        op    = 6'b000000;
        word  = 32'h0;
        case (kind)
            5'd0:  funct = 6'b000000;
            5'd1:  funct = 6'b000010;
            5'd2:  funct = 6'b000011;
            5'd3:  funct = 6'b100000;
            5'd4:  funct = 6'b100010;
            5'd5:  funct = 6'b100100;
            5'd6:  funct = 6'b100101;
            5'd7:  funct = 6'b101010;
            5'd8:  funct = 6'b001000;
            5'd9:  op    = 6'b000010;
            5'd10: op    = 6'b000011;
            5'd11: op    = 6'b000100;
            5'd12: op    = 6'b000101;
            5'd13: op    = 6'b001000;
            5'd14: op    = 6'b001010;
            5'd15: op    = 6'b001100;
            5'd16: op    = 6'b001101;
            5'd17: op    = 6'b100011;
            5'd18: op    = 6'b101011;
            default: op  = 6'b000000;
        endcase
        // Shifts take no rs; JR carries only rs; the remaining R-types carry no shamt
        if (kind <= 5'd2) begin
            word = {6'b000000, 5'd0, rt, rd, shamt, funct};
        end else if (kind <= 5'd7) begin
            word = {6'b000000, rs, rt, rd, 5'd0, funct};
        end else if (kind == 5'd8) begin
            word = {6'b000000, rs, 5'd0, 5'd0, 5'd0, funct};
        end else if (kind <= 5'd10) begin
            word = {op, target};
        end else begin
            word = {op, rs, rt, imm};
        end
        return word;
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   len_sat;

    assign len_sat = sat_len(len_i);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    count_d = '0;
                    err_d   = 1'b0;
                    if (len_sat != '0) begin
                        state_d = S_RUN;
                        addr_d  = base_i;
                        rem_d   = len_sat;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (in_valid_i) begin
                    if (is_legal(kind_i)) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = encode(kind_i, rs_i, rt_i, rd_i, shamt_i, imm_i, target_i);
                        addr_d  = addr_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                        count_d = count_q + 1'b1;
                        if (rem_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and visible outputs: cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Session pointers are always reloaded before use, so they carry no reset
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        rem_q  <= rem_d;
    end

    assign in_ready_o = (state_q == S_RUN);
    assign busy_o     = (state_q == S_RUN);
    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign count_o    = count_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, instruction-memory word-address width.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 start_i  input  1  begin a program-load session; sampled only in IDLE.
REQ-005 base_i  input  ADDR_WIDTH  first word address of the session.
REQ-006 len_i  input  ADDR_WIDTH+1  legal instructions to write, 0..2^ADDR_WIDTH.
REQ-007 in_valid_i  input  1  descriptor valid.
REQ-008 in_ready_o  output  1  descriptor accepted when in_valid_i && in_ready_o.
REQ-009 kind_i  input  5  mnemonic: 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 SLT, 8 JR, 9 J, 10 JAL, 11 BEQ, 12 BNE, 13 ADDI, 14 SLTI, 15 ANDI, 16 ORI, 17 LW, 18 SW; 19..31 illegal.
REQ-010 rs_i, rt_i, rd_i, shamt_i  input  5 each  register and shift-amount fields.
REQ-011 imm_i  input  16  immediate / branch offset; target_i  input  26  jump target.
REQ-012 we_o  output  1  instruction-memory write strobe.
REQ-013 waddr_o  output  ADDR_WIDTH  write word address; wdata_o  output  32  encoded instruction.
REQ-014 busy_o  output  1  high in RUN; done_o  output  1  one-cycle session-complete pulse.
REQ-015 err_o  output  1  sticky illegal-mnemonic flag; count_o  output  ADDR_WIDTH+1  words written this session.

Function
REQ-016 FSM states IDLE, RUN; in_ready_o = (state == RUN); busy_o = (state == RUN).
REQ-017 IDLE, start_i=1, len_i!=0: next RUN; addr<=base_i; remaining<=len_i; count_o<=0; err_o<=0.
REQ-018 IDLE, start_i=1, len_i==0: stay IDLE; done_o=1 next cycle; count_o<=0; err_o<=0.
REQ-019 start_i in RUN ignored.
REQ-020 Legal accept: next cycle we_o=1, waddr_o=addr, wdata_o=encoding; addr<=addr+1 mod 2^ADDR_WIDTH; remaining-=1; count_o+=1. Latency exactly 1 cycle.
REQ-021 R-type (kinds 0-8): op=000000, {rs,rt,rd,shamt,funct}; funct SLL 000000, SRL 000010, SRA 000011, ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, JR 001000.
REQ-022 Shifts force rs field 0; JR forces rt, rd, shamt 0; other R-types force shamt 0.
REQ-023 J/JAL: {op, target_i}; op J 000010, JAL 000011.
REQ-024 I-type: {op, rs, rt, imm_i}; op BEQ 000100, BNE 000101, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, LW 100011, SW 101011.
REQ-025 Illegal accept: no write, addr/remaining/count unchanged, err_o<=1 until next start_i or reset.
REQ-026 Legal accept with remaining==1: state<=IDLE; done_o=1 same cycle as final we_o.
REQ-027 we_o and done_o are 0 in every cycle not specified above; waddr_o/wdata_o hold last written values.
REQ-028 Address wrap from 2^ADDR_WIDTH-1 to 0 is silent; len_i > 2^ADDR_WIDTH saturates to 2^ADDR_WIDTH.

Reset
REQ-029 rst_ni low: state IDLE, in_ready_o=0, busy_o=0, we_o=0, done_o=0, err_o=0, waddr_o=0, wdata_o=0, count_o=0, immediately and asynchronously.
REQ-030 Reset mid-RUN aborts session; pending write (registered, not yet presented) discarded; no done_o.

Verification
REQ-031 base=0,len=3; ADDI rt=8 rs=0 imm=5; ADD rs=8 rt=9 rd=10; SLL rt=8 rd=9 shamt=2 -> writes 0x20080005@0, 0x01095020@1, 0x00084880@2; done_o with last; count_o=3.
REQ-032 base=62,len=4; JAL target=0x10, SW rs=29 rt=8 imm=4, BEQ rs=8 rt=9 imm=0xFFFF, JR rs=31 -> 0x0C000010@62, 0xAFA80004@63, 0x1109FFFF@0, 0x03E00008@1.
REQ-033 len=2; kind=25 then ADDI, ORI -> err_o=1, exactly 2 writes at base, base+1, count_o=2.
REQ-034 in_valid_i toggled randomly, start_i pulsed during RUN -> no extra/dropped writes, session unaffected.
REQ-035 len=0 -> done_o one cycle, no write; rst_ni low after 1 of 3 writes -> outputs at reset values, no further we_o.
